// File: rtl/router_sync_param_if.sv
// router_sync_param_if: header/write/FIFO-status bundle between the router FSM, the sync stage and the output FIFOs
interface router_sync_param_if #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 8
);
  logic              get_dest;
  logic              write_enb_reg;
  logic [DATA_W-1:0] destination;
  logic [NUM_CH-1:0] read_enb;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic              addr_err;
  logic [NUM_CH-1:0] soft_reset;
  modport master (
    output get_dest, write_enb_reg, destination, read_enb, empty, full,
    input  vld_out, write_enb, fifo_full, addr_err, soft_reset
  );
  modport slave (
    input  get_dest, write_enb_reg, destination, read_enb, empty, full,
    output vld_out, write_enb, fifo_full, addr_err, soft_reset
  );
endinterface

// File: rtl/router_sync_param.sv
// router_sync_param: latches packet destination, steers the write strobe to one of NUM_CH FIFOs,
// flags bad addresses and (with SYNC_SOFT_RESET_EN) soft-resets FIFOs left unread for TIMEOUT cycles
module router_sync_param #(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 30
) (
  input logic                clk1,
  input logic                reset,
  router_sync_param_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_CH);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] NUM_CH_V = (ADDR_W + 1)'(NUM_CH);
  logic [ADDR_W-1:0] addr_q;
  logic              addr_valid;
  logic [ADDR_W-1:0] dest_addr;
  logic              in_range;
  assign dest_addr = bus.destination[ADDR_W-1:0];
  assign in_range  = {1'b0, dest_addr} < NUM_CH_V;
  assign bus.vld_out   = ~bus.empty;
  assign bus.write_enb = NUM_CH'(bus.write_enb_reg & addr_valid) << addr_q;
  assign bus.fifo_full = addr_valid & |(bus.full & (NUM_CH'(1'b1) << addr_q));
  always_ff @(posedge clk1 or negedge reset)
    if (!reset) begin
      addr_q       <= '0;
      addr_valid   <= 1'b0;
      bus.addr_err <= 1'b0;
    end else if (bus.get_dest) begin
      addr_q       <= dest_addr;
      addr_valid   <= in_range;
      bus.addr_err <= !in_range;
    end
`ifdef SYNC_SOFT_RESET_EN
  logic [CNT_W-1:0] cnt [NUM_CH];
  // counter restarts on any read or empty cycle, and wraps to 0 when it fires
  always_ff @(posedge clk1 or negedge reset)
    if (!reset) begin
      cnt            <= '{default: '0};
      bus.soft_reset <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (!bus.vld_out[i] || bus.read_enb[i]) begin
          cnt[i]            <= '0;
          bus.soft_reset[i] <= 1'b0;
        end else if (cnt[i] == CNT_W'(TIMEOUT - 1)) begin
          cnt[i]            <= '0;
          bus.soft_reset[i] <= 1'b1;
        end else begin
          cnt[i]            <= cnt[i] + CNT_W'(1);
          bus.soft_reset[i] <= 1'b0;
        end
    end
`else
  assign bus.soft_reset = '0;
`endif
endmodule

// File: tb/tb_router_sync_param.sv
// tb_router_sync_param: directed scoreboard bench for router_sync_param (NUM_CH=3, TIMEOUT=30)
module tb_router_sync_param;
`ifdef SYNC_SOFT_RESET_EN
  localparam logic [2:0] P0 = 3'b001;
`else
  localparam logic [2:0] P0 = 3'b000;
`endif
  logic clk1 = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic [10:0] sb[$];
  router_sync_param_if #(.NUM_CH(3), .DATA_W(8)) bus ();
  router_sync_param #(.NUM_CH(3), .DATA_W(8), .TIMEOUT(30)) dut (
    .clk1 (clk1),
    .reset(reset),
    .bus  (bus.slave)
  );
  always #5 clk1 = ~clk1;
  task automatic tick();
    @(posedge clk1);
    #2;
  endtask
  task automatic expect_out(input bit ae, input bit ff, input logic [2:0] sr, input logic [2:0] wen);
    sb.push_back({ae, ff, sr, wen, ~bus.empty});
  endtask
  task automatic compare(input string tag);
    logic [10:0] e;
    logic [10:0] o;
    e = sb.pop_front();
    o = {bus.addr_err, bus.fifo_full, bus.soft_reset, bus.write_enb, bus.vld_out};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask
  task automatic ck(input string tag, input bit ae, input bit ff, input logic [2:0] sr, input logic [2:0] wen);
    #1;
    expect_out(ae, ff, sr, wen);
    compare(tag);
  endtask
  initial begin
    reset = 1'b0;
    bus.get_dest = 1'b0;
    bus.write_enb_reg = 1'b0;
    bus.destination = 8'h00;
    bus.read_enb = 3'b000;
    bus.empty = 3'b110;
    bus.full = 3'b000;
    ck("rst_hold", 0, 0, 3'b000, 3'b000);
    tick();
    ck("rst_hold2", 0, 0, 3'b000, 3'b000);
    reset = 1'b1;
    ck("rst_rel", 0, 0, 3'b000, 3'b000);
    tick();
    bus.write_enb_reg = 1'b1;
    bus.full = 3'b111;
    ck("no_dest", 0, 0, 3'b000, 3'b000);
    bus.empty = 3'b111;
    bus.write_enb_reg = 1'b0;
    bus.full = 3'b000;
    tick();
    bus.get_dest = 1'b1;
    bus.destination = 8'h8E;
    ck("sel_pre", 0, 0, 3'b000, 3'b000);
    tick();
    bus.get_dest = 1'b0;
    bus.write_enb_reg = 1'b1;
    ck("sel_wen", 0, 0, 3'b000, 3'b100);
    bus.full = 3'b100;
    ck("sel_full", 0, 1, 3'b000, 3'b100);
    bus.full = 3'b011;
    ck("sel_notfull", 0, 0, 3'b000, 3'b100);
    tick();
    bus.get_dest = 1'b1;
    bus.destination = 8'h03;
    bus.write_enb_reg = 1'b0;
    bus.full = 3'b111;
    ck("oor_pre", 0, 1, 3'b000, 3'b000);
    tick();
    bus.get_dest = 1'b0;
    bus.write_enb_reg = 1'b1;
    ck("oor_err", 1, 0, 3'b000, 3'b000);
    tick();
    bus.get_dest = 1'b1;
    bus.destination = 8'h01;
    ck("oor_hold", 1, 0, 3'b000, 3'b000);
    tick();
    bus.get_dest = 1'b0;
    ck("oor_clear", 0, 1, 3'b000, 3'b010);
    tick();
    bus.get_dest = 1'b1;
    bus.destination = 8'h04;
    bus.full = 3'b000;
    tick();
    bus.get_dest = 1'b0;
    ck("upper_ign", 0, 0, 3'b000, 3'b001);
    tick();
    bus.get_dest = 1'b1;
    bus.destination = 8'h02;
    ck("same_cyc", 0, 0, 3'b000, 3'b001);
    tick();
    bus.get_dest = 1'b0;
    ck("same_next", 0, 0, 3'b000, 3'b100);
    bus.write_enb_reg = 1'b0;
    bus.empty = 3'b110;
    for (int k = 1; k < 30; k++) begin
      tick();
      ck("to_wait", 0, 0, 3'b000, 3'b000);
    end
    tick();
    ck("to_pulse", 0, 0, P0, 3'b000);
    tick();
    ck("to_once", 0, 0, 3'b000, 3'b000);
    bus.empty = 3'b111;
    tick();
    bus.empty = 3'b110;
    for (int k = 1; k < 30; k++) begin
      tick();
      ck("to_wait2", 0, 0, 3'b000, 3'b000);
    end
    bus.read_enb = 3'b001;
    tick();
    ck("to_suppress", 0, 0, 3'b000, 3'b000);
    bus.read_enb = 3'b000;
    for (int k = 1; k < 30; k++) begin
      tick();
      ck("to_wait3", 0, 0, 3'b000, 3'b000);
    end
    tick();
    ck("to_restart", 0, 0, P0, 3'b000);
    bus.empty = 3'b111;
    tick();
    bus.get_dest = 1'b1;
    bus.destination = 8'h02;
    tick();
    bus.get_dest = 1'b0;
    bus.write_enb_reg = 1'b1;
    bus.empty = 3'b110;
    ck("rst_pre", 0, 0, 3'b000, 3'b100);
    for (int k = 0; k < 20; k++) tick();
    #1;
    reset = 1'b0;
    ck("rst_async", 0, 0, 3'b000, 3'b000);
    reset = 1'b1;
    for (int k = 1; k < 30; k++) begin
      tick();
      ck("rst_wait", 0, 0, 3'b000, 3'b000);
    end
    tick();
    ck("rst_to", 0, 0, P0, 3'b000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_sync_param.md
Name: router_sync_param

Overview:
Parametrised channel-select and synchronisation block for an N-output packet router; the successor to the fixed 1x3 sync stage.
- Latches the destination field of each packet header and steers the single input write strobe to one of NUM_CH output FIFOs.
- Reports the selected FIFO's full status and flags out-of-range addresses.
- Issues a per-channel soft reset when a FIFO holds valid data that no reader drains within TIMEOUT cycles.

Parameters:
NUM_CH, 3, number of output channels/FIFOs (2..16)
DATA_W, 8, header width; channel address = destination[ADDR_W-1:0], where localparam ADDR_W = $clog2(NUM_CH)
TIMEOUT, 30, consecutive unread-valid cycles before soft reset (>=2); counter width $clog2(TIMEOUT+1)

Ports:
clk1  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
get_dest  input  1  header strobe: latch destination this edge
write_enb_reg  input  1  write request from router FSM for current byte
destination  input  DATA_W  packet header byte carrying channel address
read_enb  input  NUM_CH  per-channel FIFO read strobes from downstream
empty  input  NUM_CH  per-channel FIFO empty flags
full  input  NUM_CH  per-channel FIFO full flags
vld_out  output  NUM_CH  per-channel data-valid = ~empty (combinational)
write_enb  output  NUM_CH  one-hot write select to FIFOs
fifo_full  output  1  full flag of the currently selected FIFO
addr_err  output  1  latched address was out of range
soft_reset  output  NUM_CH  per-channel one-cycle soft reset pulse

Behaviour:
- Reset (reset=0, asynchronous): addr_q=0, addr_valid=0, addr_err=0, all timeout counters=0, soft_reset=0. Consequently write_enb=0 and fifo_full=0. vld_out stays combinational ~empty and is unaffected by reset. Reset asserted mid-packet discards the latched address; a new get_dest is required after release.
- Address latch: on a rising edge with get_dest=1:
  - addr_q <= destination[ADDR_W-1:0].
  - addr_valid <= (that value < NUM_CH); addr_err <= !(that value < NUM_CH).
  - Upper destination bits are ignored.
  - Latched value is held until the next get_dest.
- Latency: a new address takes effect one cycle after the get_dest edge. If get_dest and write_enb_reg are high in the same cycle, write_enb uses the previous addr_q.
- write_enb (combinational): bit addr_q = write_enb_reg & addr_valid; all other bits 0. Never more than one bit high. Out-of-range address means all bits 0, so the packet is dropped.
- fifo_full (combinational): full[addr_q] & addr_valid. Out-of-range address gives 0, so the router FSM is never stalled on a nonexistent channel.
- Timeout counter i, per rising edge:
  - vld_out[i]=0 or read_enb[i]=1: counter<=0.
  - Otherwise counter<=counter+1.
  - When counter == TIMEOUT-1 and still unread-valid: soft_reset[i]<=1 for exactly one cycle and counter<=0.
  - soft_reset[i] is therefore high on the cycle after the TIMEOUT-th consecutive unread-valid cycle.
  - read_enb[i]=1 on the TIMEOUT-th cycle suppresses the pulse.
  - Channels are independent; multiple soft_reset bits may pulse together.
- Counter saturation: none needed; the counter wraps to 0 on pulse and stays below TIMEOUT.

Optional Feature:
SYNC_SOFT_RESET_EN
- Defined: timeout counters and soft_reset generation as specified above.
- Undefined: no counters are instantiated; soft_reset is tied to all zeros; the port list is unchanged. All other behaviour is identical.

Test Plan:
- Reset sequencing: hold reset=0 with empty=3'b110 -> write_enb=000, fifo_full=0, addr_err=0, soft_reset=000, vld_out=001; release reset -> outputs unchanged until get_dest.
- Address select: NUM_CH=3, destination=8'h8E, get_dest pulse, then write_enb_reg=1 -> write_enb=3'b100 from next cycle. Set full=3'b100 -> fifo_full=1; full=3'b011 -> fifo_full=0.
- Out-of-range address: destination=8'h03, get_dest -> addr_err=1 next cycle; write_enb_reg=1 -> write_enb=000, fifo_full=0 even with full=3'b111. A following destination=8'h01 clears addr_err and gives write_enb=010.
- Same-cycle get_dest/write: addr_q=0 latched, then get_dest=1 with destination=8'h02 and write_enb_reg=1 -> write_enb=001 that cycle, then 100 the next.
- Timeout (feature on, TIMEOUT=30): empty[0]=0, read_enb[0]=0 for 30 cycles -> soft_reset[0]=1 on cycle 31 only. Repeat with read_enb[0]=1 on cycle 30 -> no pulse, counter restarts.
- Async reset mid-packet: active addr=2 with a counter at 20, assert reset=0 between edges -> write_enb=000 immediately. After release, 30 further idle-valid cycles are needed for a soft_reset pulse.
